// File: rtl/spi_prog_master.sv
// Mode-0 SPI master: words pushed into a small FIFO are sent one per slave-select
// frame, with a configurable SCLK divide, inter-frame gap and bit order.
module spi_prog_master #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SCLK_DIV   = 1,
  parameter int unsigned SS_GAP     = 2,
  parameter bit          MSB_FIRST  = 1'b1,
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic                  word_valid_i,
  output logic                  word_ready_o,
  output logic                  spi_ss_o,
  output logic                  spi_sclk_o,
  output logic                  spi_mosi_o,
  output logic                  busy_o,
  output logic [LVL_W-1:0]      fifo_level_o,
  output logic [15:0]           word_count_o,
  output logic [1:0]            dbg_state_o
);

  // Handshake: word_i is taken on every clk_i edge where word_valid_i && word_ready_o;
  // the source may hold valid while ready is low and the word is taken once ready rises.

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
  localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int unsigned GAP_W = (SS_GAP > 1) ? $clog2(SS_GAP) : 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SS_GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  state_e                state_q, state_d;
  logic                  ss_q, ss_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DATA_WIDTH-1:0] shifted, head;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [15:0]           word_count_q, word_count_d;
  logic                  push, pop, can_start;

  always_comb begin
    head      = mem_q[rd_ptr_q];
    shifted   = MSB_FIRST ? {shreg_q[DATA_WIDTH-2:0], 1'b0}
                          : {1'b0, shreg_q[DATA_WIDTH-1:1]};
    push      = word_valid_i && ready_q;
    can_start = en_i && (level_q != '0);
    pop          = 1'b0;
    state_d      = state_q;
    ss_d         = ss_q;
    sclk_d       = sclk_q;
    mosi_d       = mosi_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    div_cnt_d    = div_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    word_count_d = word_count_q;

    case (state_q)
      IDLE: begin
        ss_d   = 1'b1;
        sclk_d = 1'b0;
        mosi_d = 1'b0;
        pop    = can_start;
      end
      SHIFT: begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_cnt_q == BIT_LAST) begin
            state_d      = GAP;
            ss_d         = 1'b1;
            sclk_d       = 1'b0;
            mosi_d       = 1'b0;
            gap_cnt_d    = '0;
            word_count_d = word_count_q + 16'd1;
          end else begin
            // Data only moves on the falling SCLK edge so the slave sees it stable at the rise.
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt_q + 1'b1;
            shreg_d   = shifted;
            mosi_d    = MSB_FIRST ? shifted[DATA_WIDTH-1] : shifted[0];
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == GAP_LAST) begin
          if (can_start) pop = 1'b1;
          else           state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      state_d   = SHIFT;
      ss_d      = 1'b0;
      sclk_d    = 1'b0;
      shreg_d   = head;
      mosi_d    = MSB_FIRST ? head[DATA_WIDTH-1] : head[0];
      bit_cnt_d = '0;
      div_cnt_d = '0;
    end

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (!push && pop) level_d = level_q - 1'b1;
    ready_d = (level_d != FULL_LVL);
    busy_d  = (state_d != IDLE) || (level_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= word_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      ss_q         <= 1'b1;
      sclk_q       <= 1'b0;
      mosi_q       <= 1'b0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      ss_q         <= ss_d;
      sclk_q       <= sclk_d;
      mosi_q       <= mosi_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      word_count_q <= word_count_d;
    end
  end

  assign word_ready_o = ready_q;
  assign busy_o       = busy_q;
  assign fifo_level_o = level_q;
  assign word_count_o = word_count_q;
  assign spi_ss_o     = ss_q;
  assign spi_sclk_o   = sclk_q;
  assign spi_mosi_o   = mosi_q;
  assign dbg_state_o  = state_q;

endmodule

// File: doc/spi_prog_master.md
Name: spi_prog_master

Overview:
- Synthesizable SPI master that streams DATA_WIDTH-bit program words into the SoC SPI loader port.
- Replaces the behavioural bit-banging loader: host logic pushes words over a valid/ready interface into a FIFO, and the block serialises each word as one SPI frame.
- Clock divide, inter-frame gap and bit order are configurable.
- Sits between a boot/debug word source and the loader's spi_ss/spi_sclk/spi_mosi inputs.

Parameters:
- DATA_WIDTH, 32, bits per SPI frame; minimum 2.
- FIFO_DEPTH, 4, word FIFO entries; power of 2, minimum 2.
- SCLK_DIV, 1, clk_i cycles per SCLK half-period; minimum 1.
- SS_GAP, 2, clk_i cycles spi_ss_o is held high between frames; minimum 1.
- MSB_FIRST, 1, 1 = MSB shifted first, 0 = LSB first.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- en_i  input  1  transmit enable; gates the start of new frames only.
- word_i  input  DATA_WIDTH  word to send.
- word_valid_i  input  1  word_i valid.
- word_ready_o  output  1  FIFO can accept a word.
- spi_ss_o  output  1  slave select, active-low.
- spi_sclk_o  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
- spi_mosi_o  output  1  serial data.
- busy_o  output  1  FIFO non-empty or a frame is in progress.
- fifo_level_o  output  $clog2(FIFO_DEPTH+1)  number of stored words.
- word_count_o  output  16  frames completed since reset; wraps 0xFFFF -> 0.

Behaviour:
- Reset values (asynchronous, immediate, including mid-frame):
  - spi_ss_o=1, spi_sclk_o=0, spi_mosi_o=0.
  - word_ready_o=1, busy_o=0, fifo_level_o=0, word_count_o=0.
  - FIFO emptied; FSM in IDLE.
- FIFO:
  - word_ready_o = !full, registered from the current level.
  - Push when word_valid_i && word_ready_o.
  - Pop only in the FSM LOAD transition.
  - Push and pop in the same cycle: level unchanged.
  - When full, ready is low. A pop raises ready the next cycle, and a held valid word is accepted on that edge.
  - Words leave in push order.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE:
    - ss=1, sclk=0, mosi=0.
    - If en_i && FIFO non-empty: pop the head into the shift register and go to SHIFT.
    - On that edge: ss=0, sclk=0, mosi = first bit (word[DATA_WIDTH-1] if MSB_FIRST, else word[0]).
  - SHIFT:
    - Each bit lasts 2*SCLK_DIV cycles: sclk low for SCLK_DIV cycles, then high for SCLK_DIV cycles.
    - mosi changes only at sclk high->low transitions (the slave samples on the rising edge).
    - A bit counter counts 0..DATA_WIDTH-1.
    - After the high phase of the last bit: sclk=0, ss=1, mosi=0, word_count_o += 1, go to GAP.
    - spi_ss_o is low for exactly 2*SCLK_DIV*DATA_WIDTH cycles per frame.
  - GAP:
    - ss=1 for SS_GAP cycles.
    - On the last gap cycle, apply the IDLE start rule directly (no extra IDLE cycle).
    - Back-to-back frames are therefore separated by exactly SS_GAP high cycles.
    - If no frame is started, go to IDLE.
- Latency: a push accepted at edge N into an empty FIFO, with en_i=1 and FSM in IDLE, gives spi_ss_o low after edge N+1.
- en_i deasserted mid-frame: the current frame and its gap complete; no new frame starts until en_i=1.
- busy_o = (state != IDLE) || (fifo_level_o != 0).
- All outputs are registered; no combinational path from inputs to SPI pins.

Test Plan:
- Defaults, push 0xA5A50F0F: ss falls 2 edges after the push; 32 sclk rising edges; mosi sampled at rising edges = 0xA5A50F0F MSB-first; ss low 64 cycles; word_count_o=1; busy_o returns to 0.
- en_i=0, push 4 words 0x1,0x2,0x3,0x4: word_ready_o=0 and level=4 after the 4th push, 5th valid stalls. Raise en_i: frames 1,2,3,4 in order with ss high exactly 2 cycles between; stalled 5th word accepted the cycle after the first pop; word_count_o=5 at the end.
- DATA_WIDTH=8, SCLK_DIV=3, MSB_FIRST=0, word 0x01: first mosi bit=1 then seven 0s; each sclk phase 3 cycles; ss low 48 cycles.
- en_i dropped at bit 10 of a frame with 2 words queued: the current frame completes fully; the second frame starts only after en_i re-asserts; level stays 1 meanwhile.
- rst_ni pulsed low at bit 10: ss=1, sclk=0, mosi=0, level=0, word_count_o=0 with no clock edge. A new push after release transmits cleanly from bit 0.
- Simultaneous push and pop with the FIFO at level 2: level stays 2, order is preserved, and no word is lost or duplicated across 3 frames.
